sprite_blit_engine: RTL and testbench

- Parametrised successor to the fixed-size frame-buffer draw controller.
- Copies one sprite image from a synchronous sprite ROM into the selected SRAM frame buffer (double-buffered by `even_frame`), at a software-supplied screen position.
- Adds per-pixel transparency, screen-edge clipping and X/Y mirroring.
- Sits between the software register interface and the SRAM frame-buffer arbiter.

---
 rtl/sprite_blit_engine.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_blit_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit_engine.sv
// -----------------------------------------------------------------------------
// sprite_blit_engine
//
// Copies one SPR_W x SPR_H sprite image from a synchronous sprite ROM into one
// of two SRAM frame buffers at a latched screen position. Each pixel takes two
// cycles: READ presents the ROM address, and WRITE consumes the returned word.
// The engine supports transparency, screen-edge clipping and X/Y mirroring.
//
// Ports:
//   Clk, Reset     rising-edge clock, asynchronous active-high reset
//   EN             global enable; low freezes every register and blocks writes
//   img_id, imgX, imgY, flip_x, flip_y, even_frame
//                  blit parameters, latched when Start is accepted in IDLE
//   Start          level request; must fall after Done before the next blit
//   Done           high from completion until Start falls
//   step_done      one-cycle pulse when Done rises
//   rom_addr       sprite ROM address (ROM has 1-cycle read latency)
//   rom_data       sprite ROM pixel
//   SRAM_DQ        driven with the pixel only during a write cycle, else Z
//   SRAM_WE_N      active-low write strobe
//   SRAM_OE_N      tied high (the engine never reads SRAM)
//   SRAM_ADDRESS   SRAM word address
// -----------------------------------------------------------------------------
module sprite_blit_engine #(
   parameter int          SPR_W       = 32,
   parameter int          SPR_H       = 32,
   parameter int          NUM_IMG     = 8,
   parameter int          SCREEN_W    = 640,
   parameter int          SCREEN_H    = 480,
   parameter int          FB1_BASE    = 307200,
   parameter logic [15:0] TRANSPARENT = 16'h0000,
   localparam int         IW          = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1,
   localparam int         RAW         = $clog2(NUM_IMG * SPR_W * SPR_H)
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           EN,
   input  logic [IW-1:0]  img_id,
   input  logic [9:0]     imgX,
   input  logic [9:0]     imgY,
   input  logic           flip_x,
   input  logic           flip_y,
   input  logic           even_frame,
   input  logic           Start,
   output logic           Done,
   output logic           step_done,
   output logic [RAW-1:0] rom_addr,
   input  logic [15:0]    rom_data,
   inout  wire  [15:0]    SRAM_DQ,
   output logic           SRAM_WE_N,
   output logic           SRAM_OE_N,
   output logic [19:0]    SRAM_ADDRESS
);

   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]     r_state;
   logic [CW-1:0]  r_col;
   logic [RW-1:0]  r_row;
   logic [IW-1:0]  r_img;
   logic [9:0]     r_x;
   logic [9:0]     r_y;
   logic           r_fx;
   logic           r_fy;
   logic           r_ef;
   logic [RAW-1:0] r_rom_addr;
   logic [19:0]    r_sram_addr;
   logic           r_in_bounds;
   logic           r_done;
   logic           r_step_done;

   logic           w_last_col;
   logic           w_last_row;
   logic [CW-1:0]  w_next_col;
   logic [RW-1:0]  w_next_row;
   logic [10:0]    w_px;
   logic [10:0]    w_py;
   logic           w_in_bounds;
   logic [19:0]    w_fb_addr;
   logic           w_we;

   // ROM word index of sprite pixel (col,row) after optional mirroring.
   function automatic logic [RAW-1:0] rom_index(
      input logic [IW-1:0] img,
      input logic          fx,
      input logic          fy,
      input logic [CW-1:0] col,
      input logic [RW-1:0] row
   );
      int sc;
      int sr;
      sc = fx ? (SPR_W - 1 - int'(col)) : int'(col);
      sr = fy ? (SPR_H - 1 - int'(row)) : int'(row);
      return RAW'(int'(img) * SPR_W * SPR_H + sr * SPR_W + sc);
   endfunction

   assign w_last_col = (r_col == CW'(SPR_W - 1));
   assign w_last_row = (r_row == RW'(SPR_H - 1));
   assign w_next_col = w_last_col ? CW'(0) : (r_col + CW'(1));
   assign w_next_row = w_last_col ? (r_row + RW'(1)) : r_row;

   // Screen coordinates are 11 bits, so a sprite hanging off the right or
   // bottom edge compares as out of range instead of wrapping back on screen.
   assign w_px        = 11'(r_x) + 11'(r_col);
   assign w_py        = 11'(r_y) + 11'(r_row);
   assign w_in_bounds = (w_px < 11'(SCREEN_W)) && (w_py < 11'(SCREEN_H));
   assign w_fb_addr   = (r_ef ? 20'(FB1_BASE) : 20'd0)
                      + 20'(w_py) * 20'(SCREEN_W) + 20'(w_px);

   // The strobe depends on the live ROM word, because rom_data is valid only
   // during WRITE. Because r_state resets asynchronously, a reset drops the
   // strobe immediately.
   assign w_we = (r_state == S_WRITE) && EN && r_in_bounds
               && (rom_data != TRANSPARENT);

   // Blit sequencer: latch on Start, alternate READ/WRITE per pixel, then DONE.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_col       <= CW'(0);
         r_row       <= RW'(0);
         r_img       <= IW'(0);
         r_x         <= 10'd0;
         r_y         <= 10'd0;
         r_fx        <= 1'b0;
         r_fy        <= 1'b0;
         r_ef        <= 1'b0;
         r_rom_addr  <= RAW'(0);
         r_sram_addr <= 20'd0;
         r_in_bounds <= 1'b0;
         r_done      <= 1'b0;
         r_step_done <= 1'b0;
      end else if (EN) begin
         r_step_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (Start) begin
                  r_img      <= img_id;
                  r_x        <= imgX;
                  r_y        <= imgY;
                  r_fx       <= flip_x;
                  r_fy       <= flip_y;
                  r_ef       <= even_frame;
                  r_col      <= CW'(0);
                  r_row      <= RW'(0);
                  r_rom_addr <= rom_index(img_id, flip_x, flip_y, CW'(0), RW'(0));
                  r_state    <= S_READ;
               end
            end
            S_READ: begin
               // The ROM samples rom_addr at this edge. The destination is
               // resolved here so that the write cycle drives a registered address.
               r_sram_addr <= w_fb_addr;
               r_in_bounds <= w_in_bounds;
               r_state     <= S_WRITE;
            end
            S_WRITE: begin
               r_col <= w_next_col;
               r_row <= w_next_row;
               if (w_last_col && w_last_row) begin
                  r_state <= S_DONE;
               end else begin
                  r_rom_addr <= rom_index(r_img, r_fx, r_fy, w_next_col, w_next_row);
                  r_state    <= S_READ;
               end
            end
            S_DONE: begin
               // The first DONE cycle raises Done and the pulse together.
               // Later cycles wait for Start to fall.
               if (!r_done) begin
                  r_done      <= 1'b1;
                  r_step_done <= 1'b1;
               end else if (!Start) begin
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Done         = r_done;
   assign step_done    = r_step_done;
   assign rom_addr     = r_rom_addr;
   assign SRAM_ADDRESS = r_sram_addr;
   assign SRAM_WE_N    = ~w_we;
   assign SRAM_OE_N    = 1'b1;
   assign SRAM_DQ      = w_we ? rom_data : 16'bz;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// -----------------------------------------------------------------------------
// tb_sprite_blit_engine
//
// This is a self-checking bench for sprite_blit_engine with default parameters.
// It contains a synchronous ROM model filled with $urandom data. For every blit,
// a behavioural model computes the ordered list of expected SRAM writes
// (address and data) from the sprite geometry. A negedge monitor compares
// every write strobe against that list.
// -----------------------------------------------------------------------------
module tb_sprite_blit_engine;

   localparam int NIMG = 8;
   localparam int PIX  = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic [2:0]  img_id = 3'd0;
   logic [9:0]  img_x = 10'd0;
   logic [9:0]  img_y = 10'd0;
   logic        flip_x = 1'b0;
   logic        flip_y = 1'b0;
   logic        even_frame = 1'b0;
   logic        start = 1'b0;
   logic        done;
   logic        step_done;
   logic [12:0] rom_addr;
   logic [15:0] rom_data = 16'd0;
   wire  [15:0] sram_dq;
   logic        we_n;
   logic        oe_n;
   logic [19:0] sram_addr;

   int checks = 0;
   int errors = 0;

   logic [15:0] rom_mem [0:NIMG*PIX-1];
   logic [19:0] exp_addr [$];
   logic [15:0] exp_data [$];

   int wr_count, step_cnt, first_addr, last_addr, min_addr, max_addr, first_data;

   sprite_blit_engine dut (
      .Clk(clk), .Reset(rst), .EN(en), .img_id(img_id), .imgX(img_x), .imgY(img_y),
      .flip_x(flip_x), .flip_y(flip_y), .even_frame(even_frame), .Start(start),
      .Done(done), .step_done(step_done), .rom_addr(rom_addr), .rom_data(rom_data),
      .SRAM_DQ(sram_dq), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_ADDRESS(sram_addr)
   );

   always #5 clk = ~clk;

   // synchronous sprite ROM, one cycle latency
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_rom(input bit opaque);
      for (int i = 0; i < NIMG*PIX; i++) begin
         logic [15:0] w;
         w = 16'($urandom_range(0, 65535));
         if (opaque && w == 16'd0) w = 16'd1;
         if (!opaque && $urandom_range(0, 5) == 0) w = 16'd0;
         rom_mem[i] = w;
      end
   endtask

   // expected writes in raster order of destination pixels
   task automatic build_model(input int img, input int x, input int y,
                              input bit fx, input bit fy, input bit ef);
      exp_addr.delete();
      exp_data.delete();
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            int sc, sr, px, py;
            logic [15:0] d;
            sc = fx ? 31 - c : c;
            sr = fy ? 31 - r : r;
            d  = rom_mem[img*PIX + sr*32 + sc];
            px = x + c;
            py = y + r;
            if (px < 640 && py < 480 && d != 16'd0) begin
               exp_addr.push_back(20'((ef ? 307200 : 0) + py*640 + px));
               exp_data.push_back(d);
            end
         end
      end
   endtask

   // compare process: every write strobe against the model queue
   always @(negedge clk) begin
      if (!rst) begin
         if (step_done) step_cnt++;
         check("oe_n_high", oe_n, 1);
         if (!en) check("we_n_while_en_low", we_n, 1);
         if (!we_n) begin
            if (wr_count == 0) begin
               first_addr = int'(sram_addr);
               first_data = int'(sram_dq);
            end
            last_addr = int'(sram_addr);
            if (int'(sram_addr) < min_addr) min_addr = int'(sram_addr);
            if (int'(sram_addr) > max_addr) max_addr = int'(sram_addr);
            wr_count++;
            if (exp_addr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0h, no write expected",
                        sram_addr, sram_dq);
            end else begin
               check("wr_addr", sram_addr, exp_addr[0]);
               check("wr_data", sram_dq, exp_data[0]);
               void'(exp_addr.pop_front());
               void'(exp_data.pop_front());
            end
         end
      end
   end

   task automatic run_blit(input int img, input int x, input int y, input bit fx,
                           input bit fy, input bit ef, input int en_gap_at,
                           input int reset_at, input bit drop_start,
                           output int n, output int first_rom);
      build_model(img, x, y, fx, fy, ef);
      wr_count = 0; step_cnt = 0; min_addr = 32'h7fffffff; max_addr = 0;
      @(negedge clk);
      img_id = 3'(img); img_x = 10'(x); img_y = 10'(y);
      flip_x = fx; flip_y = fy; even_frame = ef; start = 1'b1;
      @(posedge clk);
      #1;
      first_rom = int'(rom_addr);
      n = 0;
      // scramble inputs while busy; latched copies must be used
      @(negedge clk);
      img_id = 3'($urandom); img_x = 10'($urandom); img_y = 10'($urandom);
      flip_x = 1'($urandom); flip_y = 1'($urandom); even_frame = 1'($urandom);
      if (drop_start) start = 1'b0;
      while (n < 5000) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
         if (en_gap_at > 0 && n == en_gap_at) en = 1'b0;
         if (en_gap_at > 0 && n == en_gap_at + 10) en = 1'b1;
         if (reset_at > 0 && n == reset_at) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst_we_n", we_n, 1);
            check("rst_done", done, 0);
            check("rst_step_done", step_done, 0);
            check("rst_sram_addr", sram_addr, 0);
            check("rst_rom_addr", rom_addr, 0);
            start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            exp_addr.delete();
            exp_data.delete();
            return;
         end
      end
      check("done_within_budget", done, 1);
      if (!drop_start) begin
         repeat (4) @(negedge clk);
         check("done_held", done, 1);
         start = 1'b0;
         @(posedge clk);
         #1;
         check("done_fall", done, 0);
      end else begin
         repeat (2) @(negedge clk);
         check("done_after_start_low", done, 0);
      end
      check("step_done_pulses", step_cnt, 1);
      check("model_drained", exp_addr.size(), 0);
   endtask

   initial begin
      int n, fr, nz;
      fill_rom(1'b1);
      repeat (3) @(negedge clk);
      check("reset_done", done, 0);
      check("reset_step_done", step_done, 0);
      check("reset_we_n", we_n, 1);
      check("reset_oe_n", oe_n, 1);
      check("reset_sram_addr", sram_addr, 0);
      check("reset_rom_addr", rom_addr, 0);
      rst = 1'b0;

      // opaque, img 0 at origin, even buffer
      run_blit(0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n, fr);
      check("t1_latency", n, 2049);
      check("t1_writes", wr_count, 1024);
      check("t1_first_addr", first_addr, 0);
      check("t1_last_addr", last_addr, 19871);
      check("t1_first_rom", fr, 0);

      // odd buffer, img 3
      run_blit(3, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, n, fr);
      check("t2_first_rom", fr, 3072);
      check("t2_first_addr", first_addr, 307200);
      check("t2_min_addr", min_addr, 307200);
      check("t2_max_addr", max_addr, 327071);
      check("t2_writes", wr_count, 1024);

      // clipped at bottom-right corner
      run_blit(0, 620, 470, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n, fr);
      check("t3_writes", wr_count, 200);
      check("t3_max_addr", max_addr, 307199);
      check("t3_latency", n, 2049);

      // mirrored with transparency; Start dropped mid-blit
      fill_rom(1'b0);
      rom_mem[1023] = 16'h1234;
      nz = 0;
      for (int i = 0; i < PIX; i++) if (rom_mem[i] != 16'd0) nz++;
      run_blit(0, 100, 50, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, n, fr);
      check("t4_first_rom", fr, 1023);
      check("t4_first_data", first_data, 16'h1234);
      check("t4_first_addr", first_addr, 32100);
      check("t4_writes", wr_count, nz);
      check("t4_latency", n, 2049);

      // reset mid-blit, then a clean blit
      fill_rom(1'b1);
      run_blit(2, 10, 10, 1'b0, 1'b0, 1'b0, 0, 500, 1'b0, n, fr);
      check("t5_writes_before_reset", wr_count, 250);
      run_blit(1, 5, 7, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, n, fr);
      check("t5_restart_writes", wr_count, 1024);
      check("t5_restart_latency", n, 2049);

      // EN low for 10 cycles starting in a WRITE cycle
      run_blit(4, 200, 100, 1'b1, 1'b0, 1'b0, 301, 0, 1'b0, n, fr);
      check("t6_writes", wr_count, 1024);
      check("t6_latency", n, 2059);

      // random blits against the model
      fill_rom(1'b0);
      for (int k = 0; k < 4; k++) begin
         run_blit($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023),
                  1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1'b0, n, fr);
         check("rand_latency", n, 2049);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
